// File: rtl/myproject_mac_requant_pkg.sv
// Layer constants, FSM encoding and result type shared by the MAC/requant
// blocks of the pruned CNN datapath.
package myproject_mac_requant_pkg;

    localparam int IN_W   = 37;
    localparam int ACC_W  = 44;
    localparam int BIAS_W = 18;
    localparam int OUT_W  = 18;
    localparam int SHIFT  = 14;
    // Two extra bits so the bias add and the rounding constant can never wrap.
    localparam int RQ_W   = ACC_W + 2;

    typedef enum logic [1:0] {
        ST_ACC  = 2'd0,
        ST_RQ   = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             sat;
    } out_sat_t;

endpackage

// File: rtl/myproject_mac_requant_if.sv
// Product-in / activation-out handshake bundle of the MAC requantiser.
interface myproject_mac_requant_if;
    import myproject_mac_requant_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic signed [IN_W-1:0]   in_data;
    logic                     in_last;
    logic signed [BIAS_W-1:0] bias;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_sat;

    modport master (
        output in_valid, in_data, in_last, bias, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_last, bias, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );

endinterface

// File: rtl/myproject_requant_sat.sv
// Combinational bias add, round-half-up shift and saturation of an
// accumulator to the activation width; shared by all layer accumulators.
module myproject_requant_sat
    import myproject_mac_requant_pkg::*;
(
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [BIAS_W-1:0] bias,
    output out_sat_t                 res
);

    localparam logic signed [RQ_W-1:0] RND  = RQ_W'(2**(SHIFT-1));
    localparam logic signed [RQ_W-1:0] MAXV = RQ_W'(2**(OUT_W-1) - 1);
    localparam logic signed [RQ_W-1:0] MINV = ~MAXV;

    function automatic logic signed [RQ_W-1:0] round_shift(input logic signed [RQ_W-1:0] t);
        logic signed [RQ_W-1:0] r;
        r = t + RND;
        return r >>> SHIFT;
    endfunction

    function automatic out_sat_t saturate(input logic signed [RQ_W-1:0] y);
        out_sat_t o;
        if (y > MAXV) begin
            o.data = {1'b0, {(OUT_W-1){1'b1}}};
            o.sat  = 1'b1;
        end else if (y < MINV) begin
            o.data = {1'b1, {(OUT_W-1){1'b0}}};
            o.sat  = 1'b1;
        end else begin
            o.data = y[OUT_W-1:0];
            o.sat  = 1'b0;
        end
        return o;
    endfunction

    logic signed [RQ_W-1:0] acc_x;
    logic signed [RQ_W-1:0] bias_x;
    logic signed [RQ_W-1:0] t;

    // Bias shares the output's fractional bits, so align it to the accumulator.
    assign acc_x  = RQ_W'(acc);
    assign bias_x = RQ_W'(bias) <<< SHIFT;
    assign t      = acc_x + bias_x;
    assign res    = saturate(round_shift(t));

endmodule

// File: rtl/myproject_mac_requant.sv
// Accumulates signed products for one neuron, then biases, requantises and
// presents the activation through a valid/ready output register.
module myproject_mac_requant
    import myproject_mac_requant_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ce,
    myproject_mac_requant_if.slave   bus,
    output logic                     acc_ovf
);

    state_t                   state_q;
    state_t                   state_d;
    logic signed [ACC_W-1:0]  acc_p0;
    logic                     first_p0;
    logic signed [BIAS_W-1:0] bias_p0;
    logic signed [OUT_W-1:0]  out_data_p1;
    logic                     out_sat_p1;
    logic                     vld_p1;

    logic signed [IN_W-1:0]   in_data_s;
    logic signed [ACC_W-1:0]  in_x;
    logic signed [ACC_W-1:0]  acc_base;
    logic signed [ACC_W-1:0]  acc_sum;
    logic                     ovf_det;
    logic                     accept;
    logic                     out_hs;
    out_sat_t                 rq;

    assign bus.in_ready  = ce & (state_q == ST_ACC);
    assign bus.out_valid = vld_p1;
    assign bus.out_data  = out_data_p1;
    assign bus.out_sat   = out_sat_p1;

    assign accept    = bus.in_valid & bus.in_ready;
    assign out_hs    = ce & vld_p1 & bus.out_ready & (state_q == ST_HOLD);
    assign in_data_s = bus.in_data;
    assign in_x      = ACC_W'(in_data_s);
    assign acc_base  = first_p0 ? '0 : acc_p0;
    assign acc_sum   = acc_base + in_x;
    // Same-sign operands yielding an opposite-sign sum means the accumulator wrapped.
    assign ovf_det   = (acc_base[ACC_W-1] == in_x[ACC_W-1]) &&
                       (acc_sum[ACC_W-1] != acc_base[ACC_W-1]);

    myproject_requant_sat u_requant_sat (
        .acc  (acc_p0),
        .bias (bias_p0),
        .res  (rq)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_ACC;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC:  if (accept && bus.in_last) state_d = ST_RQ;
            ST_RQ:   if (ce) state_d = ST_HOLD;
            ST_HOLD: if (out_hs) state_d = ST_ACC;
            default: state_d = ST_ACC;
        endcase
    end

    // Stage p0: accumulation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_p0   <= '0;
            first_p0 <= 1'b1;
            acc_ovf  <= 1'b0;
        end else if (accept) begin
            acc_p0   <= acc_sum;
            first_p0 <= bus.in_last;
            if (ovf_det) acc_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && bus.in_last) bias_p0 <= bus.bias;
    end

    // Stage p1: requantised output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_p1 <= '0;
            out_sat_p1  <= 1'b0;
            vld_p1      <= 1'b0;
        end else if (ce && state_q == ST_RQ) begin
            out_data_p1 <= rq.data;
            out_sat_p1  <= rq.sat;
            vld_p1      <= 1'b1;
        end else if (out_hs) begin
            vld_p1      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_myproject_mac_requant.sv
// Directed bench for myproject_mac_requant with hand-computed expectations.
module tb_myproject_mac_requant;
    import myproject_mac_requant_pkg::*;

    logic clk;
    logic reset;
    logic ce;
    logic acc_ovf;
    int   checks = 0;
    int   errors = 0;

    myproject_mac_requant_if bus();

    myproject_mac_requant dut (
        .clk     (clk),
        .reset   (reset),
        .ce      (ce),
        .bus     (bus),
        .acc_ovf (acc_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic signed [IN_W-1:0] d, input logic last,
                             input logic signed [BIAS_W-1:0] b);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.bias     = b;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("in_ready_timeout", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check(tag, bus.out_valid, 1);
    endtask

    task automatic pop();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("pop_valid_low", bus.out_valid, 0);
    endtask

    logic signed [IN_W-1:0] maxp;

    initial begin
        maxp          = {1'b0, {(IN_W-1){1'b1}}};
        reset         = 1'b1;
        ce            = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.bias      = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_sat", bus.out_sat, 0);
        check("rst_acc_ovf", acc_ovf, 0);
        reset = 1'b0;
        tick();
        check("rst_in_ready", bus.in_ready, 1);

        // Two beats with bias: (65536 + 2<<14 + 8192) >> 14 = 6, latency 2
        send_beat(49152, 1'b0, 0);
        send_beat(16384, 1'b1, 2);
        check("lat_rq_not_valid", bus.out_valid, 0);
        check("lat_rq_in_ready", bus.in_ready, 0);
        tick();
        check("lat_valid", bus.out_valid, 1);
        check("basic_data", bus.out_data, 6);
        check("basic_sat", bus.out_sat, 0);
        pop();

        // Rounding half toward +inf
        send_beat(8192, 1'b1, 0);
        wait_out("rnd_pos_wait");
        check("rnd_pos_half", bus.out_data, 1);
        pop();
        send_beat(-8192, 1'b1, 0);
        wait_out("rnd_neg_half_wait");
        check("rnd_neg_half", bus.out_data, 0);
        pop();
        send_beat(-8193, 1'b1, 0);
        wait_out("rnd_neg_wait");
        check("rnd_neg", bus.out_data, -1);
        pop();

        // Saturation and the exact positive limit
        send_beat(37'sd2147483648, 1'b0, 0);
        send_beat(37'sd2147483648, 1'b1, 0);
        wait_out("sat_pos_wait");
        check("sat_pos_data", bus.out_data, 131071);
        check("sat_pos_flag", bus.out_sat, 1);
        pop();
        send_beat(-37'sd2147483648, 1'b0, 0);
        send_beat(-37'sd2147483648, 1'b1, 0);
        wait_out("sat_neg_wait");
        check("sat_neg_data", bus.out_data, -131072);
        check("sat_neg_flag", bus.out_sat, 1);
        pop();
        send_beat(37'sd2147467264, 1'b1, 0);
        wait_out("max_exact_wait");
        check("max_exact_data", bus.out_data, 131071);
        check("max_exact_sat", bus.out_sat, 0);
        pop();

        // Backpressure: result 3 held, pending beat not consumed, then restart from 0
        send_beat(49152, 1'b1, 0);
        wait_out("bp_wait");
        bus.in_valid = 1'b1;
        bus.in_data  = 16384;
        bus.in_last  = 1'b1;
        bus.bias     = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_data_stable", bus.out_data, 3);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_released", bus.out_valid, 0);
        check("bp_in_ready_after", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        tick();
        check("bp_next_valid", bus.out_valid, 1);
        check("bp_restart_data", bus.out_data, 1);
        pop();

        // ce gating mid-stream; bias on a non-last beat is ignored
        send_beat(49152, 1'b0, 100);
        bus.in_valid = 1'b1;
        bus.in_data  = 16384;
        bus.in_last  = 1'b1;
        bus.bias     = 2;
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ce_in_ready", bus.in_ready, 0);
            check("ce_no_out", bus.out_valid, 0);
        end
        ce = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        wait_out("ce_wait");
        check("ce_data", bus.out_data, 6);
        bus.out_ready = 1'b1;
        ce = 1'b0;
        tick();
        tick();
        check("ce_hold_valid", bus.out_valid, 1);
        bus.out_ready = 1'b0;
        ce = 1'b1;
        pop();

        // Overflow: 128*(2^36-1) + 127 = 2^43-1, then +1 wraps
        for (int i = 0; i < 128; i++) send_beat(maxp, 1'b0, 0);
        send_beat(127, 1'b0, 0);
        check("ovf_before", acc_ovf, 0);
        send_beat(1, 1'b1, 0);
        check("ovf_set", acc_ovf, 1);
        wait_out("ovf_wait");
        check("ovf_wrap_data", bus.out_data, -131072);
        check("ovf_wrap_sat", bus.out_sat, 1);
        pop();
        send_beat(8192, 1'b1, 0);
        wait_out("ovf_next_wait");
        check("ovf_next_data", bus.out_data, 1);
        check("ovf_sticky", acc_ovf, 1);

        // Reset in HOLD drops the result asynchronously
        reset = 1'b1;
        #1;
        check("rst_hold_valid", bus.out_valid, 0);
        check("rst_hold_ovf", acc_ovf, 0);
        tick();
        reset = 1'b0;
        tick();

        // Reset mid-accumulation discards the partial sum
        send_beat(49152, 1'b0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        send_beat(16384, 1'b1, 0);
        wait_out("rst_mid_wait");
        check("rst_mid_data", bus.out_data, 1);
        pop();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
